// File: rtl/slib_mode_counter.sv
// slib_mode_counter
//   Up/down counter with a programmable terminal value and four runtime
//   modes: wrap, modulo, saturate and one-shot. The block has registered
//   overflow/underflow pulses, a one-shot DONE flag and sticky event flags.
//
// Ports
//   CLK, RST                 clock; asynchronous active-high reset
//   CLEAR                    synchronous Q<-0, DONE<-0 (highest priority)
//   LOAD, D                  synchronous Q<-D, DONE<-0
//   ENABLE, DOWN             count-step request and direction
//   MODE                     00 wrap, 01 modulo, 10 saturate, 11 one-shot
//   LIMIT                    up-terminal value (ignored in wrap)
//   CLR_STICKY               clears STICKY_OVF / STICKY_UDF
//   Q                        counter value
//   OVERFLOW, UNDERFLOW      one-cycle pulses, coincident with wrapped/held Q
//   TC                       combinational: Q sits at the terminal
//   DONE                     one-shot completed
//   STICKY_OVF, STICKY_UDF   latched pulses
module slib_mode_counter #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLEAR,
   input  logic             LOAD,
   input  logic             ENABLE,
   input  logic             DOWN,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] LIMIT,
   input  logic             CLR_STICKY,
   output logic [WIDTH-1:0] Q,
   output logic             OVERFLOW,
   output logic             UNDERFLOW,
   output logic             TC,
   output logic             DONE,
   output logic             STICKY_OVF,
   output logic             STICKY_UDF
);

   typedef enum logic [1:0] {
      M_WRAP    = 2'b00,
      M_MODULO  = 2'b01,
      M_SAT     = 2'b10,
      M_ONESHOT = 2'b11
   } mode_t;

   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   mode_t            mode;
   logic             at_top;
   logic             at_bot;
   logic [WIDTH-1:0] q_nxt;
   logic             ovf_nxt;
   logic             udf_nxt;
   logic             done_nxt;

   assign mode = mode_t'(MODE);

   // Up-terminal: all-ones in wrap; otherwise LIMIT or beyond, so a value
   // loaded above LIMIT still terminates on the next up step.
   assign at_top = (mode == M_WRAP) ? (Q == ALL_ONES) : (Q >= LIMIT);
   assign at_bot = (Q == '0);
   assign TC     = DOWN ? at_bot : at_top;

   always_comb begin
      q_nxt    = Q;
      ovf_nxt  = 1'b0;
      udf_nxt  = 1'b0;
      done_nxt = DONE;
      if (CLEAR) begin
         q_nxt    = '0;
         done_nxt = 1'b0;
      end else if (LOAD) begin
         q_nxt    = D;
         done_nxt = 1'b0;
      end else if (ENABLE && !(mode == M_ONESHOT && DONE)) begin
         if (!DOWN) begin
            if (at_top) begin
               ovf_nxt = 1'b1;
               q_nxt   = (mode == M_SAT) ? Q : '0;
               if (mode == M_ONESHOT) done_nxt = 1'b1;
            end else begin
               q_nxt = Q + 1'b1;
            end
         end else begin
            if (at_bot) begin
               udf_nxt = 1'b1;
               case (mode)
                  M_WRAP:  q_nxt = ALL_ONES;
                  M_SAT:   q_nxt = Q;
                  default: q_nxt = LIMIT;
               endcase
               if (mode == M_ONESHOT) done_nxt = 1'b1;
            end else begin
               q_nxt = Q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Q          <= '0;
         OVERFLOW   <= 1'b0;
         UNDERFLOW  <= 1'b0;
         DONE       <= 1'b0;
         STICKY_OVF <= 1'b0;
         STICKY_UDF <= 1'b0;
      end else begin
         Q         <= q_nxt;
         OVERFLOW  <= ovf_nxt;
         UNDERFLOW <= udf_nxt;
         DONE      <= done_nxt;
         // A new event in the same edge beats CLR_STICKY.
         if (ovf_nxt)         STICKY_OVF <= 1'b1;
         else if (CLR_STICKY) STICKY_OVF <= 1'b0;
         if (udf_nxt)         STICKY_UDF <= 1'b1;
         else if (CLR_STICKY) STICKY_UDF <= 1'b0;
      end
   end

endmodule
